// File: rtl/boot_load_sequencer_if.sv
// Boot-load bus bundle: start request, synchronous ROM read port, download write port,
// execute handoff and status/checksum outputs. The master side is the sequencer.
interface boot_load_sequencer_if;
    logic        start;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        dn_go;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wait;
    logic        execute_enable;
    logic [15:0] execute_addr;
    logic        busy;
    logic        done;
    logic [7:0]  csum;
    logic        csum_valid;

    modport master (
        input  start, rom_data, dn_wait,
        output rom_addr, dn_go, dn_wr, dn_addr, dn_data,
               execute_enable, execute_addr, busy, done, csum, csum_valid
    );

    modport slave (
        output start, rom_data, dn_wait,
        input  rom_addr, dn_go, dn_wr, dn_addr, dn_data,
               execute_enable, execute_addr, busy, done, csum, csum_valid
    );
endinterface

// File: rtl/boot_load_sequencer.sv
// Copies ROM_LEN bytes from a synchronous boot ROM to a download sink, then pulses execute.
// Optional running checksum of written bytes is enabled by defining BOOT_LOAD_CSUM_EN.
module boot_load_sequencer #(
    parameter int unsigned ROM_LEN   = 276,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] EXEC_ADDR = 16'h0000,
    parameter int unsigned WR_HOLD   = 1
) (
    input logic                   clk_sys,
    input logic                   reset,
    boot_load_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        GAP   = 3'd3,
        EXEC  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [15:0] LAST_IDX  = 16'(ROM_LEN - 1);
    localparam logic [15:0] HOLD_LAST = 16'(WR_HOLD - 1);

    state_t      state_q, state_d;
    logic [15:0] index_q, index_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        start_ok;
    logic        write_done;

    assign start_ok   = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign write_done = (state_q == WRITE) && !bus.dn_wait && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        hold_d    = hold_q;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    index_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                hold_d    = '0;
                dn_data_d = bus.rom_data;
                dn_addr_d = BASE_ADDR + index_q;
                state_d   = WRITE;
            end
            WRITE: begin
                if (write_done) begin
                    state_d = GAP;
                end else if (!bus.dn_wait) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            GAP: begin
                if (index_q == LAST_IDX) begin
                    state_d = EXEC;
                end else begin
                    index_d = index_q + 16'd1;
                    state_d = FETCH;
                end
            end
            EXEC: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            hold_q    <= '0;
            dn_addr_q <= '0;
            dn_data_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            hold_q    <= hold_d;
            dn_addr_q <= dn_addr_d;
            dn_data_q <= dn_data_d;
        end
    end

    // The ROM registers its address, so present the next index a cycle early; data lands during FETCH.
    assign bus.rom_addr       = index_d;
    assign bus.dn_go          = (state_q == FETCH) || (state_q == WRITE) || (state_q == GAP);
    assign bus.dn_wr          = (state_q == WRITE);
    assign bus.dn_addr        = dn_addr_q;
    assign bus.dn_data        = dn_data_q;
    assign bus.execute_enable = (state_q == EXEC);
    assign bus.execute_addr   = EXEC_ADDR;
    assign bus.busy           = (state_q == FETCH) || (state_q == WRITE) ||
                                (state_q == GAP)   || (state_q == EXEC);
    assign bus.done           = (state_q == DONE);

`ifdef BOOT_LOAD_CSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (write_done) begin
            csum_d = csum_q + dn_data_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign bus.csum       = csum_q;
    assign bus.csum_valid = (state_q == DONE);
`else
    assign bus.csum       = 8'h00;
    assign bus.csum_valid = 1'b0;
`endif

endmodule

// File: doc/boot_load_sequencer.md
BOOT_LOAD_SEQUENCER -- requirements
Module: boot_load_sequencer

Interface
REQ-001 SHALL have parameter ROM_LEN, default 276, meaning the number of boot bytes copied (legal range 1..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000, meaning the first dn_addr written.
REQ-003 SHALL have parameter EXEC_ADDR, default 16'h0000, meaning the value driven on execute_addr.
REQ-004 SHALL have parameter WR_HOLD, default 1, meaning dn_wr high cycles per byte (minimum 1).
REQ-005 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: request a copy, sampled only in IDLE or DONE.
REQ-008 SHALL have port rom_addr, output, 16 bits: boot ROM read address.
REQ-009 SHALL have port rom_data, input, 8 bits: boot ROM data, valid 1 cycle after rom_addr (synchronous ROM).
REQ-010 SHALL have port dn_go, output, 1 bit: download window active.
REQ-011 SHALL have ports dn_wr (1 bit), dn_addr (16 bits) and dn_data (8 bits), all outputs: the write strobe, address and data.
REQ-012 SHALL have port dn_wait, input, 1 bit: the sink stalls the current write.
REQ-013 SHALL have ports execute_enable (1 bit) and execute_addr (16 bits), both outputs: a one-cycle execute pulse and its target address.
REQ-014 SHALL have ports busy and done, outputs, 1 bit each: a copy is in progress, and the copy plus execute has completed.
REQ-015 SHALL have ports csum (8 bits) and csum_valid (1 bit), both outputs; see Configuration.

Function
REQ-016 SHALL implement states IDLE, FETCH, WRITE, GAP, EXEC and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL clear the index to 0, set dn_go=1 and go to FETCH.
- Otherwise IDLE and DONE hold.
REQ-018 FETCH SHALL last exactly 1 cycle.
- rom_addr = index.
- Then go to WRITE, latching rom_data into dn_data on WRITE entry.
REQ-019 WRITE SHALL hold dn_wr=1, dn_addr=(BASE_ADDR+index) mod 65536 and stable dn_data.
- It leaves after WR_HOLD cycles in which dn_wait=0; cycles with dn_wait=1 do not count and keep dn_wr=1.
REQ-020 GAP SHALL last 1 cycle with dn_wr=0.
- If index=ROM_LEN-1, go to EXEC; else increment index and go to FETCH.
REQ-021 EXEC SHALL last 1 cycle.
- execute_enable=1, dn_go=0, then go to DONE.
REQ-022 execute_addr SHALL equal EXEC_ADDR at all times after reset.
REQ-023 busy SHALL be 1 in FETCH, WRITE, GAP and EXEC.
REQ-024 done SHALL be 1 only in DONE.
REQ-025 start asserted while busy=1 SHALL be ignored.
REQ-026 dn_wait asserted outside WRITE SHALL have no effect.
REQ-027 Minimum cycles from start to execute_enable SHALL be ROM_LEN*(WR_HOLD+2)+1.
REQ-028 dn_wr SHALL never be high in two consecutive bytes without an intervening GAP low cycle.

Reset
REQ-029 reset=1 SHALL, at the next edge, force IDLE from any state, including mid-copy and mid-stall.
- Zeroes: index, rom_addr, dn_go, dn_wr, dn_addr, dn_data, execute_enable, busy, done, csum, csum_valid.
- execute_addr = EXEC_ADDR.
REQ-030 On reset, no partial dn_wr pulse SHALL be extended.
- After reset, the first write occurs only after a new start.

Configuration
REQ-031 With macro BOOT_LOAD_CSUM_EN defined, csum SHALL be the mod-256 sum of all bytes strobed on dn_wr in the current copy.
- csum is cleared on start.
- csum_valid = 1 in DONE, cleared on start or reset.
REQ-032 Without BOOT_LOAD_CSUM_EN, csum and csum_valid SHALL be constant 0 and the adder SHALL not be built.
- All other behaviour is identical.

Verification
REQ-033 Scenario: ROM_LEN=4, rom bytes 11,22,33,44, start pulse, dn_wait=0.
- Expect 4 dn_wr pulses at addr 0..3 with those data.
- Expect execute_enable 1 cycle at cycle 13, then done=1.
- Expect csum=AA when the macro is defined.
REQ-034 Scenario: dn_wait=1 for 5 cycles during byte 2.
- Expect dn_wr held high 6 cycles at addr 2, data unchanged.
- Expect execute delayed by exactly 5 cycles.
REQ-035 Scenario: reset during WRITE of byte 100.
- Expect all outputs 0 the next cycle and IDLE.
- Then start gives a full copy beginning at addr 0.
REQ-036 Scenario: BASE_ADDR=16'hFFFE, ROM_LEN=4.
- Expect dn_addr FFFE, FFFF, 0000, 0001.
REQ-037 Scenario: start pulsed mid-copy, then again in DONE.
- Expect the first pulse ignored; the second restarts the copy with done=0 and csum_valid=0.
REQ-038 Scenario: ROM_LEN=1, WR_HOLD=3.
- Expect one 3-cycle dn_wr, then GAP, then EXEC, with execute_enable at cycle 6.
